mem_stage: RTL and testbench

//  Memory-access (MEM) pipeline stage between EX and the GPR write-back port. Performs

---
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: word load/store over a req/rdy bus, stalls while a transfer is
// pending, and registers the GPR write-back triple plus a misaligned-access flag.
module mem_stage #(
    parameter int WORD_W     = 32,
    parameter int BUS_ADDR_W = 30,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_en,
    input  logic [1:0]            ex_mem_op,
    input  logic [WORD_W-1:0]     ex_out,
    input  logic [WORD_W-1:0]     ex_mem_wr_data,
    input  logic [REG_ADDR_W-1:0] ex_dst_addr,
    input  logic                  ex_gpr_we_,
    output logic                  bus_req,
    output logic                  bus_rw,
    output logic [BUS_ADDR_W-1:0] bus_addr,
    output logic [WORD_W-1:0]     bus_wr_data,
    input  logic [WORD_W-1:0]     bus_rd_data,
    input  logic                  bus_rdy,
    output logic                  busy,
    output logic                  mem_en,
    output logic [REG_ADDR_W-1:0] mem_dst_addr,
    output logic                  mem_gpr_we_,
    output logic [WORD_W-1:0]     mem_out,
    output logic                  mem_misalign
);

    localparam logic [1:0] OP_LW = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    drop_q, drop_d;
    logic [WORD_W-1:0]       rd_data_q, rd_data_d;
    logic                    bus_req_q, bus_req_d;
    logic                    mem_en_q, mem_en_d;
    logic [REG_ADDR_W-1:0]   mem_dst_addr_q, mem_dst_addr_d;
    logic                    mem_gpr_we_q, mem_gpr_we_d;
    logic [WORD_W-1:0]       mem_out_q, mem_out_d;
    logic                    mem_misalign_q, mem_misalign_d;

    logic is_load, is_store, is_mem, aligned, misalign, mem_req, ld_sel;

    assign is_load  = (ex_mem_op == OP_LW);
    assign is_store = (ex_mem_op == OP_SW);
    assign is_mem   = is_load | is_store;
    assign aligned  = (ex_out[1:0] == 2'b00);
    assign misalign = ex_en & is_mem & ~aligned;
    assign mem_req  = ex_en & is_mem & aligned & ~flush;
    // Latched bus data is only the result while the finished load is still in EX.
    assign ld_sel   = (state_q == ST_DONE) & is_load;

    assign bus_rw      = ~is_store;
    assign bus_addr    = ex_out[BUS_ADDR_W+1:2];
    assign bus_wr_data = ex_mem_wr_data;
    assign bus_req     = bus_req_q;
    assign busy        = ((state_q == ST_IDLE) & mem_req) | (state_q == ST_ACCESS);

    assign mem_en       = mem_en_q;
    assign mem_dst_addr = mem_dst_addr_q;
    assign mem_gpr_we_  = mem_gpr_we_q;
    assign mem_out      = mem_out_q;
    assign mem_misalign = mem_misalign_q;

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (mem_req) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A flushed transfer still runs to completion; its result is dropped.
                if (flush) drop_d = 1'b1;
                if (bus_rdy) begin
                    rd_data_d = bus_rd_data;
                    drop_d    = 1'b0;
                    state_d   = (drop_q | flush) ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || !stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        bus_req_d = (state_d == ST_ACCESS);
    end

    always_comb begin
        mem_en_d       = mem_en_q;
        mem_dst_addr_d = mem_dst_addr_q;
        mem_gpr_we_d   = mem_gpr_we_q;
        mem_out_d      = mem_out_q;
        mem_misalign_d = mem_misalign_q;
        if (flush || (!stall && busy)) begin
            mem_en_d       = 1'b0;
            mem_gpr_we_d   = 1'b1;
            mem_misalign_d = 1'b0;
        end else if (!stall) begin
            mem_en_d       = ex_en;
            mem_dst_addr_d = ex_dst_addr;
            mem_out_d      = ld_sel ? rd_data_q : ex_out;
            mem_gpr_we_d   = (is_store | misalign) ? 1'b1 : ex_gpr_we_;
            mem_misalign_d = misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            drop_q         <= 1'b0;
            rd_data_q      <= '0;
            bus_req_q      <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_dst_addr_q <= '0;
            mem_gpr_we_q   <= 1'b1;
            mem_out_q      <= '0;
            mem_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            drop_q         <= drop_d;
            rd_data_q      <= rd_data_d;
            bus_req_q      <= bus_req_d;
            mem_en_q       <= mem_en_d;
            mem_dst_addr_q <= mem_dst_addr_d;
            mem_gpr_we_q   <= mem_gpr_we_d;
            mem_out_q      <= mem_out_d;
            mem_misalign_q <= mem_misalign_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-timed bus sequences.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, ex_en, ex_gpr_we_, bus_rdy;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_out, ex_mem_wr_data, bus_rd_data, bus_wr_data, mem_out;
    logic [4:0]  ex_dst_addr, mem_dst_addr;
    logic [29:0] bus_addr;
    logic        bus_req, bus_rw, busy, mem_en, mem_gpr_we_, mem_misalign;

    int total = 0;
    int bad   = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_en(ex_en), .ex_mem_op(ex_mem_op), .ex_out(ex_out),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_),
        .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy), .busy(busy),
        .mem_en(mem_en), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_out(mem_out), .mem_misalign(mem_misalign)
    );

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [4:0]  dst;
        logic        we_n;
        logic        fl;
        logic        e_en;
        logic        e_we_n;
        logic [31:0] e_out;
        logic        e_mis;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        ex_en = 0; ex_mem_op = 2'b00; ex_out = 0; ex_mem_wr_data = 0;
        ex_dst_addr = 0; ex_gpr_we_ = 1; flush = 0; stall = 0; bus_rdy = 0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] dst, input logic we_n);
        ex_en = 1; ex_mem_op = op; ex_out = a; ex_mem_wr_data = wd;
        ex_dst_addr = dst; ex_gpr_we_ = we_n;
    endtask

    initial begin
        vt[0] = '{1, 2'b00, 32'h0000_0055, 5'd3,  0, 0, 1, 0, 32'h0000_0055, 0};
        vt[1] = '{1, 2'b11, 32'h0000_0104, 5'd4,  0, 0, 1, 0, 32'h0000_0104, 0};
        vt[2] = '{1, 2'b01, 32'h0000_0102, 5'd5,  0, 0, 1, 1, 32'h0000_0102, 1};
        vt[3] = '{1, 2'b10, 32'h0000_0203, 5'd6,  0, 0, 1, 1, 32'h0000_0203, 1};
        vt[4] = '{0, 2'b01, 32'h0000_0100, 5'd7,  1, 0, 0, 1, 32'h0000_0100, 0};
        vt[5] = '{0, 2'b01, 32'h0000_0101, 5'd8,  0, 0, 0, 0, 32'h0000_0101, 0};
        vt[6] = '{1, 2'b00, 32'hFFFF_FFFF, 5'd31, 1, 0, 1, 1, 32'hFFFF_FFFF, 0};
        vt[7] = '{1, 2'b01, 32'h0000_0100, 5'd9,  0, 1, 0, 1, 32'h0000_0000, 0};

        reset = 1; bus_rd_data = 0; idle_in();
        repeat (2) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_we_n", mem_gpr_we_, 1);
        chk("rst_dst", mem_dst_addr, 0);
        chk("rst_out", mem_out, 0);
        chk("rst_misalign", mem_misalign, 0);
        reset = 0;

        // single-cycle table: no bus activity expected for any of these
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vt[i].op, vt[i].addr, 32'hA5A5_0000, vt[i].dst, vt[i].we_n);
            ex_en = vt[i].en; flush = vt[i].fl;
            #1;
            chk($sformatf("v%0d_busy", i), busy, 0);
            @(negedge clk);
            chk($sformatf("v%0d_req", i), bus_req, 0);
            chk($sformatf("v%0d_en", i), mem_en, vt[i].e_en);
            chk($sformatf("v%0d_we_n", i), mem_gpr_we_, vt[i].e_we_n);
            chk($sformatf("v%0d_mis", i), mem_misalign, vt[i].e_mis);
            if (!vt[i].fl) begin
                chk($sformatf("v%0d_out", i), mem_out, vt[i].e_out);
                chk($sformatf("v%0d_dst", i), mem_dst_addr, vt[i].dst);
            end
            idle_in();
        end

        // load, rdy on the second request cycle
        @(negedge clk);
        busy_cnt = 0;
        drive(2'b01, 32'h0000_0100, 0, 5'd7, 0);
        #1;
        busy_cnt += busy;
        chk("ld_req_c0", bus_req, 0);
        chk("ld_addr", bus_addr, 30'h40);
        chk("ld_rw", bus_rw, 1);
        @(negedge clk); #1;
        busy_cnt += busy;
        chk("ld_req_c1", bus_req, 1);
        @(negedge clk);
        bus_rdy = 1; bus_rd_data = 32'hDEAD_BEEF;
        #1;
        busy_cnt += busy;
        chk("ld_req_c2", bus_req, 1);
        @(negedge clk);
        bus_rdy = 0;
        #1;
        busy_cnt += busy;
        chk("ld_req_done", bus_req, 0);
        chk("ld_en_done", mem_en, 0);
        @(negedge clk);
        chk("ld_en", mem_en, 1);
        chk("ld_out", mem_out, 32'hDEAD_BEEF);
        chk("ld_we_n", mem_gpr_we_, 0);
        chk("ld_dst", mem_dst_addr, 7);
        idle_in();
        #1;
        busy_cnt += busy;
        chk("ld_busy_cycles", busy_cnt, 3);

        // store, rdy on the first request cycle
        @(negedge clk);
        drive(2'b10, 32'h0000_0204, 32'h1234_5678, 5'd9, 0);
        #1;
        chk("st_busy", busy, 1);
        chk("st_rw", bus_rw, 0);
        chk("st_addr", bus_addr, 30'h81);
        chk("st_wdata", bus_wr_data, 32'h1234_5678);
        @(negedge clk);
        bus_rdy = 1;
        #1;
        chk("st_req", bus_req, 1);
        @(negedge clk);
        bus_rdy = 0;
        #1;
        chk("st_busy_done", busy, 0);
        @(negedge clk);
        chk("st_en", mem_en, 1);
        chk("st_we_n", mem_gpr_we_, 1);
        chk("st_mis", mem_misalign, 0);
        idle_in();

        // flush one cycle into ACCESS, rdy three cycles later, then a fresh load
        @(negedge clk);
        drive(2'b01, 32'h0000_0300, 0, 5'd10, 0);
        @(negedge clk);
        flush = 1;
        #1;
        chk("fl_req_c1", bus_req, 1);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            flush = 0;
            if (c == 4) begin bus_rdy = 1; bus_rd_data = 32'h1111_1111; end
            #1;
            chk($sformatf("fl_req_c%0d", c), bus_req, 1);
            chk($sformatf("fl_busy_c%0d", c), busy, 1);
            chk($sformatf("fl_en_c%0d", c), mem_en, 0);
        end
        @(negedge clk);
        bus_rdy = 0;
        chk("fl_req_end", bus_req, 0);
        chk("fl_en_end", mem_en, 0);
        chk("fl_we_n_end", mem_gpr_we_, 1);
        drive(2'b01, 32'h0000_0600, 0, 5'd11, 0);
        #1;
        chk("fl_idle_reissue", busy, 1);
        @(negedge clk);
        bus_rdy = 1; bus_rd_data = 32'h0000_600D;
        #1;
        chk("fl2_req", bus_req, 1);
        chk("fl2_en", mem_en, 0);
        @(negedge clk);
        bus_rdy = 0;
        @(negedge clk);
        chk("fl2_out", mem_out, 32'h0000_600D);
        chk("fl2_dst", mem_dst_addr, 11);
        chk("fl2_en_done", mem_en, 1);
        idle_in();

        // stall held four cycles in DONE
        @(negedge clk);
        drive(2'b01, 32'h0000_0400, 0, 5'd5, 0);
        @(negedge clk);
        bus_rdy = 1; bus_rd_data = 32'hCAFE_F00D;
        @(negedge clk);
        bus_rdy = 0; stall = 1;
        #1;
        chk("sd_busy_c2", busy, 0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            if (c == 6) stall = 0;
            #1;
            chk($sformatf("sd_busy_c%0d", c), busy, 0);
            chk($sformatf("sd_req_c%0d", c), bus_req, 0);
            chk($sformatf("sd_en_c%0d", c), mem_en, 0);
        end
        @(negedge clk);
        chk("sd_en", mem_en, 1);
        chk("sd_out", mem_out, 32'hCAFE_F00D);
        chk("sd_we_n", mem_gpr_we_, 0);
        chk("sd_dst", mem_dst_addr, 5);
        idle_in();

        // reset in the middle of a transfer
        @(negedge clk);
        drive(2'b01, 32'h0000_0500, 0, 5'd12, 0);
        @(negedge clk);
        chk("rs_req_pre", bus_req, 1);
        reset = 1; idle_in();
        @(negedge clk);
        chk("rs_req", bus_req, 0);
        chk("rs_busy", busy, 0);
        chk("rs_we_n", mem_gpr_we_, 1);
        chk("rs_en", mem_en, 0);
        reset = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
